// File: rtl/pipe_mux_reg_if.sv
// Handshake bundle for pipe_mux_reg: channelised input side, registered output side.
interface pipe_mux_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
);
  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [WIDTH-1:0]   out_data;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/pipe_mux_reg.sv
// N-to-1 channel mux captured into a 2-entry skid buffer (head + skid).
// in_ready is registered and depends only on skid occupancy, so there is
// no combinational path from out_ready back to in_ready.
module pipe_mux_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input logic            clk,
  input logic            rst,
  pipe_mux_reg_if.slave  bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] head_data_q, skid_data_q;
  logic             head_err_q, skid_err_q;

  logic [WIDTH-1:0] new_data;
  logic             new_err;
  logic             accept, pop, out_valid;
  logic             load_head, load_skid, skid_to_head;

  assign out_valid = (state_q != StEmpty);
  assign accept    = bus.in_valid & in_ready_q;
  assign pop       = out_valid & bus.out_ready;

  // Channel select; an out-of-range select stores zero data flagged as an error.
  always_comb begin
    new_data = '0;
    new_err  = 1'b1;
    for (int k = 0; k < int'(N); k++) begin
      if (int'(bus.sel) == k) begin
        new_data = bus.in_data[k*WIDTH +: WIDTH];
        new_err  = 1'b0;
      end
    end
  end

  // Occupancy next-state and buffer load controls; flush overrides everything.
  always_comb begin
    state_d      = state_q;
    load_head    = 1'b0;
    load_skid    = 1'b0;
    skid_to_head = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d   = StOne;
          load_head = 1'b1;
        end
      end
      StOne: begin
        if (accept && pop) begin
          load_head = 1'b1;
        end else if (accept) begin
          state_d   = StFull;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          state_d      = StOne;
          skid_to_head = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (bus.flush) begin
      state_d      = StEmpty;
      load_head    = 1'b0;
      load_skid    = 1'b0;
      skid_to_head = 1'b0;
    end
  end

  // Occupancy state and registered ready (ready == skid slot free next cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  // Data registers hold unless loaded; valid state alone qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      if (load_head) begin
        head_data_q <= new_data;
        head_err_q  <= new_err;
      end else if (skid_to_head) begin
        head_data_q <= skid_data_q;
        head_err_q  <= skid_err_q;
      end
      if (load_skid) begin
        skid_data_q <= new_data;
        skid_err_q  <= new_err;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_data_q;
  assign bus.out_err   = head_err_q;

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Directed self-checking bench for pipe_mux_reg (N=4 and N=3 instances).
module tb_pipe_mux_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_mux_reg_if #(.WIDTH(32), .N(4), .SEL_W(2)) bus4 ();
  pipe_mux_reg_if #(.WIDTH(32), .N(3), .SEL_W(2)) bus3 ();

  pipe_mux_reg #(.WIDTH(32), .N(4), .SEL_W(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  pipe_mux_reg #(.WIDTH(32), .N(3), .SEL_W(2)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Advance one edge and settle; inputs change and outputs are read here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put word w on channel 0 of the N=4 instance and select it.
  task automatic offer4(input logic [31:0] w);
    bus4.in_data  = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, w};
    bus4.sel      = 2'd0;
    bus4.in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus4.out_valid);
    end
    n_checks++;
    if (bus4.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus4.in_ready);
    end
    n_checks++;
    if (bus4.out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h want 0", bus4.out_data);
    end
    n_checks++;
    if (bus4.out_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_err: got %b want 0", bus4.out_err);
    end
    n_checks++;
    if (bus3.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_n3_out_valid: got %b want 0", bus3.out_valid);
    end
  endtask

  task automatic test_basic();
    bus4.in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    bus4.sel       = 2'd2;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    n_checks++;
    if (bus4.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_valid: got %b want 1", bus4.out_valid);
    end
    n_checks++;
    if (bus4.out_data !== 32'h33) begin
      n_fail++; $display("FAIL basic_data: got %h want 00000033", bus4.out_data);
    end
    n_checks++;
    if (bus4.out_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_err: got %b want 0", bus4.out_err);
    end
    step();
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain: got %b want 0", bus4.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus4.out_ready = 1'b0;
    offer4(32'hA0A0A0A0);
    step();
    n_checks++;
    if (bus4.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_one: got %b want 1", bus4.in_ready);
    end
    offer4(32'hB0B0B0B0);
    step();
    n_checks++;
    if (bus4.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_full: got %b want 0", bus4.in_ready);
    end
    offer4(32'hC0C0C0C0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (bus4.out_data !== 32'hA0A0A0A0 || bus4.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold: got %h/%b want a0a0a0a0/1", bus4.out_data, bus4.out_valid);
      end
    end
    bus4.out_ready = 1'b1;
    step();
    n_checks++;
    if (bus4.out_data !== 32'hB0B0B0B0 || bus4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: got %h/rdy %b want b0b0b0b0/1", bus4.out_data, bus4.in_ready);
    end
    step();
    bus4.in_valid = 1'b0;
    n_checks++;
    if (bus4.out_data !== 32'hC0C0C0C0 || bus4.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_third: got %h/%b want c0c0c0c0/1", bus4.out_data, bus4.out_valid);
    end
    step();
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty: got %b want 0", bus4.out_valid);
    end
  endtask

  task automatic test_bad_select();
    bus3.in_data   = {32'hCC, 32'hBB, 32'hAA};
    bus3.sel       = 2'd3;
    bus3.in_valid  = 1'b1;
    bus3.out_ready = 1'b1;
    step();
    bus3.sel = 2'd0;
    n_checks++;
    if (bus3.out_data !== 32'h0 || bus3.out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL badsel_err: got %h/%b want 0/1", bus3.out_data, bus3.out_err);
    end
    step();
    bus3.in_valid = 1'b0;
    n_checks++;
    if (bus3.out_data !== 32'hAA || bus3.out_err !== 1'b0 || bus3.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL badsel_next: got %h/%b/%b want aa/0/1",
               bus3.out_data, bus3.out_err, bus3.out_valid);
    end
    step();
    n_checks++;
    if (bus3.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL badsel_empty: got %b want 0", bus3.out_valid);
    end
  endtask

  task automatic test_flush();
    bus4.out_ready = 1'b0;
    offer4(32'h11110000);
    step();
    offer4(32'h22220000);
    step();
    offer4(32'h33330000);
    bus4.flush = 1'b1;
    step();
    bus4.flush = 1'b0;
    n_checks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: got valid %b rdy %b want 0/1", bus4.out_valid, bus4.in_ready);
    end
    // Input offered alongside a flush in ONE must be discarded too.
    offer4(32'h44440000);
    step();
    offer4(32'h55550000);
    bus4.flush = 1'b1;
    step();
    bus4.flush    = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_one: got %b want 0", bus4.out_valid);
    end
    step();
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_ghost: got %b/%h want 0", bus4.out_valid, bus4.out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [1:0]  s;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      v = 32'h1000 + i;
      s = 2'(i % 4);
      bus4.in_data  = {v + 32'h300, v + 32'h200, v + 32'h100, v};
      bus4.sel      = s;
      bus4.in_valid = 1'b1;
      step();
      n_checks++;
      if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b1 ||
          bus4.out_data !== v + 32'h100 * 32'(s)) begin
        n_fail++;
        $display("FAIL stream_%0d: got %h/%b/%b want %h/1/1", i, bus4.out_data,
                 bus4.out_valid, bus4.in_ready, v + 32'h100 * 32'(s));
      end
    end
    bus4.in_valid = 1'b0;
    step();
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_drain: got %b want 0", bus4.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus4.out_ready = 1'b0;
    offer4(32'h77777777);
    step();
    offer4(32'h88888888);
    step();
    offer4(32'h99999999);
    bus4.flush = 1'b1;
    rst        = 1'b1;
    step();
    rst           = 1'b0;
    bus4.flush    = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    n_checks++;
    if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0 || bus4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: got %b/%h/%b want 0/0/1",
               bus4.out_valid, bus4.out_data, bus4.in_ready);
    end
    step();
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got %b want 0", bus4.out_valid);
    end
  endtask

  initial begin
    bus4.in_data = '0; bus4.sel = '0; bus4.in_valid = 1'b0;
    bus4.flush = 1'b0; bus4.out_ready = 1'b0;
    bus3.in_data = '0; bus3.sel = '0; bus3.in_valid = 1'b0;
    bus3.flush = 1'b0; bus3.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_select();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mux_reg.md
PIPE_MUX_REG -- requirements
Module: pipe_mux_reg

Interface
REQ-001 Parameter: WIDTH, 32, data width of each input channel and of the output.
REQ-002 Parameter: N, 4, number of input channels (2..16).
REQ-003 Parameter: SEL_W, 2, select width; the integrator SHALL set it so that 2**SEL_W >= N.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: in_data  input  N*WIDTH  concatenated channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port: sel  input  SEL_W  channel select, sampled with in_valid.
REQ-009 Port: in_valid  input  1  upstream offers in_data/sel.
REQ-010 Port: in_ready  output  1  block can accept; a transfer occurs when in_valid and in_ready are both 1.
REQ-011 Port: flush  input  1  synchronous pipeline flush (branch/exception kill).
REQ-012 Port: out_data  output  WIDTH  selected, registered data.
REQ-013 Port: out_err  output  1  1 when the entry at the head was accepted with sel >= N.
REQ-014 Port: out_valid  output  1  head entry valid.
REQ-015 Port: out_ready  input  1  downstream accepts; a pop occurs when out_valid and out_ready are both 1.

Function
REQ-016 The block SHALL select channel sel at acceptance time and store {err, data} in a 2-entry skid buffer (head register plus skid register).
REQ-017 If sel >= N, the stored data SHALL be all zeros and err SHALL be 1; otherwise err SHALL be 0.
REQ-018 in_ready SHALL be a registered signal equal to 1 exactly when the skid register is empty; it SHALL have no combinational path from out_ready.
REQ-019 Occupancy states: EMPTY (0 entries), ONE (head only), FULL (head and skid); out_valid SHALL be 1 in ONE and FULL.
REQ-020 EMPTY + accept -> ONE; out_valid SHALL rise on the next cycle (1-cycle latency).
REQ-021 ONE + accept + no pop -> FULL.
REQ-022 ONE + accept + pop -> ONE, with the head loaded from the new input.
REQ-023 ONE + pop only -> EMPTY.
REQ-024 FULL + pop -> ONE, with the skid entry moved to the head; no accept is possible in FULL.
REQ-025 Outputs SHALL present entries in acceptance order and never duplicate or drop an entry except on flush.
REQ-026 The block SHALL sustain one transfer per cycle when out_ready is held at 1.
REQ-027 While out_valid=1 and out_ready=0, out_data and out_err SHALL remain stable.
REQ-028 flush=1 SHALL go to EMPTY on the next edge, discard both entries and any input accepted in that cycle, and set in_ready=1 the next cycle.
REQ-029 When flush and a pop coincide, the pop counts and the state still goes to EMPTY.
REQ-030 Data registers SHALL hold their values when not loaded; only the valid bits govern the outputs.

Reset
REQ-031 rst=1 SHALL take priority over flush and all handshakes, and on the next edge SHALL force EMPTY: out_valid=0, in_ready=1, out_data=0, out_err=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries with no pop reported after reset.

Verification
REQ-033 Basic pass: N=4, WIDTH=32, channels 0x11,0x22,0x33,0x44, sel=2, in_valid pulse, out_ready=1 -> out_valid=1 one cycle later with out_data=0x33, out_err=0.
REQ-034 Backpressure: out_ready=0 with 3 offered words A,B,C -> A and B accepted, in_ready=0 after B, C held; then out_ready=1 -> A, B, C out in order, none lost.
REQ-035 Bad select: N=3, SEL_W=2, sel=3 -> out_data=0, out_err=1; the next sel=0 entry gives out_err=0.
REQ-036 Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input never appears.
REQ-037 Streaming: 100 back-to-back transfers with out_ready=1 -> 100 outputs on consecutive cycles, in_ready held at 1.
REQ-038 Reset mid-stream in FULL with flush=1 -> next cycle out_valid=0, out_data=0, in_ready=1.
